// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
// It carries the ALU/IR status inputs, the write strobes, the mux selects and the debug state code.
interface multicycle_control_fsm_if;
    logic       overflow;
    logic       zero;
    logic [5:0] opcode;
    logic [5:0] funct;

    logic       PCWrite;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       ABWrite;
    logic       AluOutWrite;
    logic       MDRWrite;
    logic       EPCWrite;
    logic [2:0] aluOP;
    logic [2:0] muxIord;
    logic [1:0] muxAluSrcA;
    logic [1:0] muxAluSrcB;
    logic [2:0] muxRegDst;
    logic [2:0] muxMemToReg;
    logic [2:0] muxPCSource;
    logic       rstOut;
    logic       halted;
    logic [6:0] state_dbg;

    modport master (
        input  overflow, zero, opcode, funct,
        output PCWrite, memRead, memWrite, IRWrite, RegWrite, ABWrite,
               AluOutWrite, MDRWrite, EPCWrite, aluOP, muxIord, muxAluSrcA,
               muxAluSrcB, muxRegDst, muxMemToReg, muxPCSource, rstOut,
               halted, state_dbg
    );

    modport slave (
        output overflow, zero, opcode, funct,
        input  PCWrite, memRead, memWrite, IRWrite, RegWrite, ABWrite,
               AluOutWrite, MDRWrite, EPCWrite, aluOP, muxIord, muxAluSrcA,
               muxAluSrcB, muxRegDst, muxMemToReg, muxPCSource, rstOut,
               halted, state_dbg
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: a Moore FSM with memory wait states,
// overflow/unknown-opcode exceptions that vector through memory, and a halt state for break.
module multicycle_control_fsm #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4,
    parameter bit EXC_EN  = 1'b1
) (
    input logic clk,
    input logic rst,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [6:0] {
        ST_INIT, ST_SP, FETCH, FETCH_IR, DECODE, EX_R, WB_R, EX_I, WB_I,
        ADDR, MEM_RD, LW_MDR, LW_WB, MEM_WR, BRANCH, JUMP, BREAK, HALT,
        EXC_OVF, EXC_OPC, EXC_RD, EXC_MDR, EXC_JMP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               excOvf_q, excOvf_d;

    logic lastBeat;
    logic isRType;
    logic isBreak;
    logic rTraps;

    assign lastBeat = (cnt_q == CNT_W'(MEM_LAT - 1));
    assign isRType  = (bus.opcode == 6'h00) &&
                      (bus.funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
    assign isBreak  = (bus.opcode == 6'h00) && (bus.funct == 6'h0d);
    assign rTraps   = (bus.funct == 6'h20) || (bus.funct == 6'h22);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            excOvf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            excOvf_q <= excOvf_d;
        end
    end

    // The wait counter only advances inside the memory states; every other path clears it.
    always_comb begin
        state_d  = ST_INIT;
        cnt_d    = '0;
        excOvf_d = excOvf_q;
        case (state_q)
            ST_INIT:  state_d = ST_SP;
            ST_SP:    state_d = FETCH;
            FETCH: begin
                if (lastBeat) state_d = FETCH_IR;
                else begin
                    state_d = FETCH;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            FETCH_IR: state_d = DECODE;
            DECODE: begin
                if (isRType)                                      state_d = EX_R;
                else if (isBreak)                                 state_d = BREAK;
                else if (bus.opcode inside {6'h08, 6'h0a})        state_d = EX_I;
                else if (bus.opcode inside {6'h23, 6'h2b})        state_d = ADDR;
                else if (bus.opcode inside {6'h04, 6'h05})        state_d = BRANCH;
                else if (bus.opcode == 6'h02)                     state_d = JUMP;
                else if (EXC_EN)                                  state_d = EXC_OPC;
                else                                              state_d = FETCH;
            end
            EX_R:     state_d = (EXC_EN && bus.overflow && rTraps) ? EXC_OVF : WB_R;
            WB_R:     state_d = FETCH;
            EX_I:     state_d = (EXC_EN && bus.overflow && bus.opcode == 6'h08) ? EXC_OVF : WB_I;
            WB_I:     state_d = FETCH;
            ADDR:     state_d = (bus.opcode == 6'h23) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (lastBeat) state_d = LW_MDR;
                else begin
                    state_d = MEM_RD;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            LW_MDR:   state_d = LW_WB;
            LW_WB:    state_d = FETCH;
            MEM_WR: begin
                if (lastBeat) state_d = FETCH;
                else begin
                    state_d = MEM_WR;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            BREAK:    state_d = HALT;
            HALT:     state_d = HALT;
            EXC_OVF: begin
                excOvf_d = 1'b1;
                state_d  = EXC_RD;
            end
            EXC_OPC: begin
                excOvf_d = 1'b0;
                state_d  = EXC_RD;
            end
            EXC_RD: begin
                if (lastBeat) state_d = EXC_MDR;
                else begin
                    state_d = EXC_RD;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            EXC_MDR:  state_d = EXC_JMP;
            EXC_JMP:  state_d = FETCH;
            default:  state_d = ST_INIT;
        endcase
    end

    // Outputs follow the state; funct/opcode/zero only refine the ALU op and branch decision.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ABWrite     = 1'b0;
        bus.AluOutWrite = 1'b0;
        bus.MDRWrite    = 1'b0;
        bus.EPCWrite    = 1'b0;
        bus.aluOP       = 3'b000;
        bus.muxIord     = 3'b000;
        bus.muxAluSrcA  = 2'b00;
        bus.muxAluSrcB  = 2'b00;
        bus.muxRegDst   = 3'b000;
        bus.muxMemToReg = 3'b000;
        bus.muxPCSource = 3'b000;
        bus.rstOut      = 1'b0;
        bus.halted      = 1'b0;
        bus.state_dbg   = state_q;
        case (state_q)
            ST_INIT: bus.rstOut = 1'b1;
            ST_SP: begin
                bus.RegWrite  = 1'b1;
                bus.muxRegDst = 3'b100;
            end
            FETCH: bus.memRead = 1'b1;
            FETCH_IR: begin
                bus.muxAluSrcB  = 2'b01;
                bus.aluOP       = 3'b001;
                bus.muxPCSource = 3'b001;
                bus.PCWrite     = 1'b1;
                bus.IRWrite     = 1'b1;
            end
            DECODE: begin
                bus.ABWrite     = 1'b1;
                bus.muxAluSrcB  = 2'b11;
                bus.aluOP       = 3'b001;
                bus.AluOutWrite = 1'b1;
            end
            EX_R: begin
                bus.muxAluSrcA  = 2'b10;
                bus.AluOutWrite = 1'b1;
                case (bus.funct)
                    6'h20:   bus.aluOP = 3'b001;
                    6'h22:   bus.aluOP = 3'b010;
                    6'h24:   bus.aluOP = 3'b011;
                    6'h25:   bus.aluOP = 3'b100;
                    6'h2a:   bus.aluOP = 3'b111;
                    default: bus.aluOP = 3'b000;
                endcase
            end
            WB_R: begin
                bus.muxRegDst   = 3'b010;
                bus.muxMemToReg = 3'b110;
                bus.RegWrite    = 1'b1;
            end
            EX_I: begin
                bus.muxAluSrcA  = 2'b10;
                bus.muxAluSrcB  = 2'b10;
                bus.AluOutWrite = 1'b1;
                bus.aluOP       = (bus.opcode == 6'h0a) ? 3'b111 : 3'b001;
            end
            WB_I: begin
                bus.muxMemToReg = 3'b110;
                bus.RegWrite    = 1'b1;
            end
            ADDR: begin
                bus.muxAluSrcA  = 2'b10;
                bus.muxAluSrcB  = 2'b10;
                bus.aluOP       = 3'b001;
                bus.AluOutWrite = 1'b1;
            end
            MEM_RD: begin
                bus.muxIord = 3'b001;
                bus.memRead = 1'b1;
            end
            LW_MDR: bus.MDRWrite = 1'b1;
            LW_WB: begin
                bus.muxMemToReg = 3'b001;
                bus.RegWrite    = 1'b1;
            end
            MEM_WR: begin
                bus.muxIord  = 3'b001;
                bus.memWrite = 1'b1;
            end
            BRANCH: begin
                bus.muxAluSrcA  = 2'b10;
                bus.aluOP       = 3'b010;
                bus.muxPCSource = 3'b010;
                bus.PCWrite     = ((bus.opcode == 6'h04) &&  bus.zero) ||
                                  ((bus.opcode == 6'h05) && !bus.zero);
            end
            JUMP: begin
                bus.muxPCSource = 3'b011;
                bus.PCWrite     = 1'b1;
            end
            BREAK: begin
                bus.muxAluSrcB  = 2'b01;
                bus.aluOP       = 3'b010;
                bus.muxPCSource = 3'b001;
                bus.PCWrite     = 1'b1;
            end
            HALT: bus.halted = 1'b1;
            EXC_OVF, EXC_OPC: begin
                bus.EPCWrite   = 1'b1;
                bus.muxAluSrcB = 2'b01;
                bus.aluOP      = 3'b010;
            end
            EXC_RD: begin
                bus.muxIord = excOvf_q ? 3'b011 : 3'b010;
                bus.memRead = 1'b1;
            end
            EXC_MDR: bus.MDRWrite = 1'b1;
            EXC_JMP: begin
                bus.muxPCSource = 3'b100;
                bus.PCWrite     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: three instances with different latency/exception settings
// share one instruction stream, each checked cycle by cycle against an expected-output script.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       pcw, mr, mw, irw, rw, abw, aow, mdrw, epcw;
        logic [2:0] alu;
        logic [2:0] iord;
        logic [1:0] srcA, srcB;
        logic [2:0] regDst, memToReg, pcSrc;
        logic       rstOut, halted;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ovf = 1'b0;
    logic       zr  = 1'b0;
    logic [5:0] op  = 6'h00;
    logic [5:0] fn  = 6'h00;

    int checks = 0;
    int errors = 0;

    outs_t obs [3];
    outs_t expQ [3][$];

    always #5 clk = ~clk;

    multicycle_control_fsm_if ifA ();
    multicycle_control_fsm_if ifB ();
    multicycle_control_fsm_if ifC ();

    assign ifA.overflow = ovf;  assign ifA.zero = zr;  assign ifA.opcode = op;  assign ifA.funct = fn;
    assign ifB.overflow = ovf;  assign ifB.zero = zr;  assign ifB.opcode = op;  assign ifB.funct = fn;
    assign ifC.overflow = ovf;  assign ifC.zero = zr;  assign ifC.opcode = op;  assign ifC.funct = fn;

    multicycle_control_fsm #(.MEM_LAT(1), .CNT_W(4), .EXC_EN(1'b1)) uA (.clk(clk), .rst(rst), .bus(ifA));
    multicycle_control_fsm #(.MEM_LAT(3), .CNT_W(4), .EXC_EN(1'b1)) uB (.clk(clk), .rst(rst), .bus(ifB));
    multicycle_control_fsm #(.MEM_LAT(2), .CNT_W(4), .EXC_EN(1'b0)) uC (.clk(clk), .rst(rst), .bus(ifC));

    assign obs[0] = {ifA.PCWrite, ifA.memRead, ifA.memWrite, ifA.IRWrite, ifA.RegWrite, ifA.ABWrite,
                     ifA.AluOutWrite, ifA.MDRWrite, ifA.EPCWrite, ifA.aluOP, ifA.muxIord, ifA.muxAluSrcA,
                     ifA.muxAluSrcB, ifA.muxRegDst, ifA.muxMemToReg, ifA.muxPCSource, ifA.rstOut, ifA.halted};
    assign obs[1] = {ifB.PCWrite, ifB.memRead, ifB.memWrite, ifB.IRWrite, ifB.RegWrite, ifB.ABWrite,
                     ifB.AluOutWrite, ifB.MDRWrite, ifB.EPCWrite, ifB.aluOP, ifB.muxIord, ifB.muxAluSrcA,
                     ifB.muxAluSrcB, ifB.muxRegDst, ifB.muxMemToReg, ifB.muxPCSource, ifB.rstOut, ifB.halted};
    assign obs[2] = {ifC.PCWrite, ifC.memRead, ifC.memWrite, ifC.IRWrite, ifC.RegWrite, ifC.ABWrite,
                     ifC.AluOutWrite, ifC.MDRWrite, ifC.EPCWrite, ifC.aluOP, ifC.muxIord, ifC.muxAluSrcA,
                     ifC.muxAluSrcB, ifC.muxRegDst, ifC.muxMemToReg, ifC.muxPCSource, ifC.rstOut, ifC.halted};

    function automatic int latOf(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit excOf(input int i);
        return (i != 2);
    endfunction

    function automatic outs_t idle();
        outs_t o;
        o = '0;
        return o;
    endfunction

    function automatic outs_t initOuts();
        outs_t o;
        o = '0;
        o.rstOut = 1'b1;
        return o;
    endfunction

    // Expected-output script: each instruction is expanded into the cycles it must take.
    task automatic push(input int i, input outs_t o, input int n);
        for (int k = 0; k < n; k++) expQ[i].push_back(o);
    endtask

    task automatic pushException(input int i, input bit fromOvf);
        outs_t o;
        o = idle(); o.epcw = 1; o.srcB = 2'b01; o.alu = 3'b010;               push(i, o, 1);
        o = idle(); o.mr = 1; o.iord = fromOvf ? 3'b011 : 3'b010;             push(i, o, latOf(i));
        o = idle(); o.mdrw = 1;                                               push(i, o, 1);
        o = idle(); o.pcw = 1; o.pcSrc = 3'b100;                              push(i, o, 1);
    endtask

    task automatic expandInstr(input int i, input logic [5:0] opc, input logic [5:0] fun,
                               input logic ov, input logic z, output bit stop);
        outs_t o;
        int    lat;
        bit    exc;
        lat  = latOf(i);
        exc  = excOf(i);
        stop = 0;
        o = idle(); o.mr = 1;                                                 push(i, o, lat);
        o = idle(); o.srcB = 2'b01; o.alu = 3'b001; o.pcSrc = 3'b001; o.pcw = 1; o.irw = 1;
        push(i, o, 1);
        o = idle(); o.abw = 1; o.srcB = 2'b11; o.alu = 3'b001; o.aow = 1;    push(i, o, 1);
        if (opc == 6'h00 && fun inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) begin
            o = idle(); o.srcA = 2'b10; o.aow = 1;
            o.alu = (fun == 6'h20) ? 3'b001 : (fun == 6'h22) ? 3'b010 :
                    (fun == 6'h24) ? 3'b011 : (fun == 6'h25) ? 3'b100 : 3'b111;
            push(i, o, 1);
            if ((fun == 6'h20 || fun == 6'h22) && ov && exc) pushException(i, 1'b1);
            else begin
                o = idle(); o.regDst = 3'b010; o.memToReg = 3'b110; o.rw = 1; push(i, o, 1);
            end
        end else if (opc == 6'h00 && fun == 6'h0d) begin
            o = idle(); o.srcB = 2'b01; o.alu = 3'b010; o.pcSrc = 3'b001; o.pcw = 1;
            push(i, o, 1);
            stop = 1;
        end else if (opc == 6'h08 || opc == 6'h0a) begin
            o = idle(); o.srcA = 2'b10; o.srcB = 2'b10; o.aow = 1;
            o.alu = (opc == 6'h0a) ? 3'b111 : 3'b001;
            push(i, o, 1);
            if (opc == 6'h08 && ov && exc) pushException(i, 1'b1);
            else begin
                o = idle(); o.memToReg = 3'b110; o.rw = 1;                   push(i, o, 1);
            end
        end else if (opc == 6'h23 || opc == 6'h2b) begin
            o = idle(); o.srcA = 2'b10; o.srcB = 2'b10; o.alu = 3'b001; o.aow = 1;
            push(i, o, 1);
            if (opc == 6'h23) begin
                o = idle(); o.iord = 3'b001; o.mr = 1;                        push(i, o, lat);
                o = idle(); o.mdrw = 1;                                       push(i, o, 1);
                o = idle(); o.memToReg = 3'b001; o.rw = 1;                    push(i, o, 1);
            end else begin
                o = idle(); o.iord = 3'b001; o.mw = 1;                        push(i, o, lat);
            end
        end else if (opc == 6'h04 || opc == 6'h05) begin
            o = idle(); o.srcA = 2'b10; o.alu = 3'b010; o.pcSrc = 3'b010;
            o.pcw = (opc == 6'h04) ? z : ~z;
            push(i, o, 1);
        end else if (opc == 6'h02) begin
            o = idle(); o.pcSrc = 3'b011; o.pcw = 1;                          push(i, o, 1);
        end else if (exc) begin
            pushException(i, 1'b0);
        end
    endtask

    task automatic buildScript(input int i, input int n);
        outs_t o;
        bit    stop;
        expQ[i].delete();
        push(i, initOuts(), 1);
        o = idle(); o.rw = 1; o.regDst = 3'b100;                              push(i, o, 1);
        stop = 0;
        while (expQ[i].size() < n && !stop) expandInstr(i, op, fn, ovf, zr, stop);
        o = idle(); o.halted = 1;
        while (expQ[i].size() < n) push(i, o, 1);
    endtask

    // Resets every instance, holds one instruction on the inputs and releases reset.
    task automatic startScenario(input logic [5:0] opc, input logic [5:0] fun,
                                 input logic ov, input logic z, input int n);
        @(negedge clk);
        rst = 1'b0;
        op  = opc;
        fn  = fun;
        ovf = ov;
        zr  = z;
        @(negedge clk);
        for (int i = 0; i < 3; i++) buildScript(i, n);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        outs_t want;
        want = initOuts();
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== want) begin
                errors++;
                $display("[TB] FAIL reset_async dut%0d got %h want %h", i, obs[i], want);
            end
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== want) begin
                errors++;
                $display("[TB] FAIL reset_hold dut%0d got %h want %h", i, obs[i], want);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0] functs [5];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        for (int t = 0; t < 10; t++) begin
            startScenario(6'h00, functs[t % 5], 1'(t / 5), 1'($urandom_range(0, 1)), 36);
            for (int c = 0; c < 36; c++) begin
                if (c > 0) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs[i] !== expQ[i][c]) begin
                        errors++;
                        $display("[TB] FAIL rtype fn=%h ov=%0d dut%0d cyc%0d got %h want %h",
                                 fn, ovf, i, c, obs[i], expQ[i][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_itype();
        for (int t = 0; t < 4; t++) begin
            startScenario((t < 2) ? 6'h08 : 6'h0a, 6'($urandom_range(0, 63)), 1'(t % 2),
                          1'($urandom_range(0, 1)), 36);
            for (int c = 0; c < 36; c++) begin
                if (c > 0) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs[i] !== expQ[i][c]) begin
                        errors++;
                        $display("[TB] FAIL itype op=%h ov=%0d dut%0d cyc%0d got %h want %h",
                                 op, ovf, i, c, obs[i], expQ[i][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_memory();
        for (int t = 0; t < 2; t++) begin
            startScenario((t == 0) ? 6'h23 : 6'h2b, 6'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 36);
            for (int c = 0; c < 36; c++) begin
                if (c > 0) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs[i] !== expQ[i][c]) begin
                        errors++;
                        $display("[TB] FAIL memory op=%h dut%0d cyc%0d got %h want %h",
                                 op, i, c, obs[i], expQ[i][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 4; t++) begin
            startScenario((t < 2) ? 6'h04 : 6'h05, 6'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)), 1'(t % 2), 30);
            for (int c = 0; c < 30; c++) begin
                if (c > 0) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs[i] !== expQ[i][c]) begin
                        errors++;
                        $display("[TB] FAIL branch op=%h zero=%0d dut%0d cyc%0d got %h want %h",
                                 op, zr, i, c, obs[i], expQ[i][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_jump_break();
        for (int t = 0; t < 2; t++) begin
            startScenario((t == 0) ? 6'h02 : 6'h00, 6'h0d, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 30);
            for (int c = 0; c < 30; c++) begin
                if (c > 0) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs[i] !== expQ[i][c]) begin
                        errors++;
                        $display("[TB] FAIL jump_break op=%h dut%0d cyc%0d got %h want %h",
                                 op, i, c, obs[i], expQ[i][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_exceptions();
        logic [5:0] ops [4];
        logic [5:0] fns [4];
        ops = '{6'h3f, 6'h00, 6'h08, 6'h00};
        fns = '{6'h00, 6'h3b, 6'h00, 6'h22};
        for (int t = 0; t < 4; t++) begin
            startScenario(ops[t], fns[t], 1'b1, 1'($urandom_range(0, 1)), 40);
            for (int c = 0; c < 40; c++) begin
                if (c > 0) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs[i] !== expQ[i][c]) begin
                        errors++;
                        $display("[TB] FAIL exception op=%h fn=%h dut%0d cyc%0d got %h want %h",
                                 op, fn, i, c, obs[i], expQ[i][c]);
                    end
                end
            end
        end
    endtask

    // lw on the MEM_LAT=3 instance is in MEM_RD during cycles 8..10; reset lands mid-count.
    task automatic test_reset_mid_mem();
        outs_t want;
        want = initOuts();
        startScenario(6'h23, 6'h00, 1'b0, 1'b0, 10);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expQ[i][c]) begin
                    errors++;
                    $display("[TB] FAIL midreset_pre dut%0d cyc%0d got %h want %h",
                             i, c, obs[i], expQ[i][c]);
                end
            end
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== want) begin
                errors++;
                $display("[TB] FAIL midreset_idle dut%0d got %h want %h", i, obs[i], want);
            end
        end
        startScenario(6'h23, 6'h00, 1'b0, 1'b0, 30);
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expQ[i][c]) begin
                    errors++;
                    $display("[TB] FAIL midreset_post dut%0d cyc%0d got %h want %h",
                             i, c, obs[i], expQ[i][c]);
                end
            end
        end
    endtask

    task automatic test_random_mix();
        logic [5:0] rOps [10];
        logic [5:0] rFns [5];
        logic [5:0] pickOp, pickFn;
        int k;
        rOps = '{6'h00, 6'h08, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h00, 6'h00};
        rFns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        for (int t = 0; t < 16; t++) begin
            k      = $urandom_range(0, 9);
            pickOp = (k == 8) ? 6'($urandom_range(0, 63)) : rOps[k];
            pickFn = (k == 9) ? 6'($urandom_range(0, 63)) : rFns[$urandom_range(0, 4)];
            startScenario(pickOp, pickFn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 40);
            for (int c = 0; c < 40; c++) begin
                if (c > 0) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs[i] !== expQ[i][c]) begin
                        errors++;
                        $display("[TB] FAIL random op=%h fn=%h ov=%0d z=%0d dut%0d cyc%0d got %h want %h",
                                 op, fn, ovf, zr, i, c, obs[i], expQ[i][c]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_memory();
        test_branch();
        test_jump_break();
        test_exceptions();
        test_reset_mid_mem();
        test_random_mix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
